// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: hunts SOF, captures a length-prefixed
// payload, verifies an XOR checksum and replays good frames over valid/ready.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF     = 8'h55,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);
  // state      | meaning
  // ST_IDLE    | hunting for SOF, other bytes discarded
  // ST_LEN     | waiting for the length byte
  // ST_PAYLOAD | capturing L payload bytes into the buffer
  // ST_CSUM    | waiting for the checksum byte
  // ST_DRAIN   | replaying the buffer to the consumer

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_ZERO  = '0;

  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CSUM, ST_DRAIN} state_t;

  state_t           state;
  logic [7:0]       buf_mem [MAX_LEN];
  logic [7:0]       len_q;
  logic [7:0]       csum;
  logic [7:0]       len_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_nxt;
  logic [TMR_W-1:0] tmr;
  logic             in_frame;

  assign len_m1   = len_q - 8'd1;
  assign rd_nxt   = rd_idx + 1'b1;
  assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);

  always_ff @(posedge clk) begin
    if (state == ST_PAYLOAD && rx_done) buf_mem[wr_idx] <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      csum      <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      tmr       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_OVERRUN;
      busy      <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      // Down-counting inter-byte timer; a byte landing on the expiry cycle wins.
      if (in_frame && !rx_done) begin
        if (tmr == '0) begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          frame_err <= 1'b1;
          err_code  <= ERR_TIMEOUT;
        end else begin
          tmr <= tmr - 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (rx_done && rx_data == SOF) begin
            state <= ST_LEN;
            busy  <= 1'b1;
            tmr   <= TMR_LOAD;
          end
        end
        ST_LEN: begin
          if (rx_done) begin
            tmr <= TMR_LOAD;
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
            end else begin
              len_q  <= rx_data;
              csum   <= rx_data;
              wr_idx <= '0;
              state  <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_done) begin
            tmr    <= TMR_LOAD;
            csum   <= csum ^ rx_data;
            wr_idx <= wr_idx + 1'b1;
            if (8'(wr_idx) == len_m1) state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_done) begin
            if (rx_data == csum) begin
              frame_ok  <= 1'b1;
              rd_idx    <= '0;
              out_valid <= 1'b1;
              out_data  <= buf_mem[IDX_ZERO];
              out_last  <= (len_q == 8'd1);
              state     <= ST_DRAIN;
            end else begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
          end
        end
        ST_DRAIN: begin
          // No room for a new byte while replaying; drop it but keep draining.
          if (rx_done) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (out_ready) begin
            if (out_last) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              rd_idx   <= rd_nxt;
              out_data <= buf_mem[rd_nxt];
              out_last <= (8'(rd_nxt) == len_m1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good/bad frames, timeout boundary,
// backpressure with overrun, and asynchronous reset mid-frame.
module tb_uart_rx_frame_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ok_cnt   = 0;
  int err_cnt  = 0;
  int e0;
  int o0;
  bit valid_seen = 1'b0;
  logic [7:0] q_data[$];
  bit         q_last[$];
  int         q_cyc[$];

  uart_rx_frame_ctrl #(.SOF(8'h55), .MAX_LEN(16), .TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Sample mid-low-phase, after the bench has driven inputs at the falling edge.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
    if (out_valid) valid_seen = 1'b1;
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    valid_seen = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check_val("wait_idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #1;
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_frame_err", 32'(frame_err), 0);
    check_val("rst_err_code", 32'(err_code), 0);
    check_val("rst_out_data", 32'(out_data), 0);
    idle(2);
    reset = 1'b0;
    idle(2);

    // Good frame, with a stray byte before SOF
    clear_mon();
    out_ready = 1'b1;
    e0 = err_cnt;
    o0 = ok_cnt;
    rx_byte(8'h13);
    check_val("stray_busy", 32'(busy), 0);
    rx_byte(8'h55);
    check_val("sof_busy", 32'(busy), 1);
    rx_byte(8'h03);
    rx_byte(8'hA5);
    rx_byte(8'h3C);
    rx_byte(8'h0F);
    rx_byte(8'h95);
    check_val("good_frame_ok", 32'(frame_ok), 1);
    check_val("good_first_valid", 32'(out_valid), 1);
    check_val("good_first_data", 32'(out_data), 'hA5);
    idle(4);
    check_val("good_ok_cnt", 32'(ok_cnt - o0), 1);
    check_val("good_err_cnt", 32'(err_cnt - e0), 0);
    check_val("good_busy_end", 32'(busy), 0);
    check_val("good_nbytes", 32'(q_data.size()), 3);
    if (q_data.size() == 3) begin
      check_val("good_b0", 32'(q_data[0]), 'hA5);
      check_val("good_b1", 32'(q_data[1]), 'h3C);
      check_val("good_b2", 32'(q_data[2]), 'h0F);
      check_val("good_last", {29'd0, q_last[0], q_last[1], q_last[2]}, 'b001);
      check_val("good_consec1", 32'(q_cyc[1] - q_cyc[0]), 1);
      check_val("good_consec2", 32'(q_cyc[2] - q_cyc[1]), 1);
    end

    // Checksum error then recovery
    clear_mon();
    rx_byte(8'h55);
    rx_byte(8'h02);
    rx_byte(8'h11);
    rx_byte(8'h22);
    rx_byte(8'h00);
    check_val("csum_err", 32'(frame_err), 1);
    check_val("csum_code", 32'(err_code), 2);
    check_val("csum_busy", 32'(busy), 0);
    rx_byte(8'h55);
    rx_byte(8'h01);
    rx_byte(8'h7E);
    rx_byte(8'h7F);
    check_val("recov_ok", 32'(frame_ok), 1);
    check_val("recov_data", 32'(out_data), 'h7E);
    check_val("recov_last", 32'(out_last), 1);
    idle(3);
    check_val("recov_nbytes", 32'(q_data.size()), 1);

    // Bad lengths, then a maximum-length frame (payload 00..0F, csum 10)
    clear_mon();
    e0 = err_cnt;
    rx_byte(8'h55);
    rx_byte(8'h00);
    check_val("len0_err", 32'(frame_err), 1);
    check_val("len0_code", 32'(err_code), 1);
    rx_byte(8'h55);
    rx_byte(8'h11);
    check_val("len17_err", 32'(frame_err), 1);
    check_val("len17_code", 32'(err_code), 1);
    idle(2);
    check_val("badlen_no_valid", 32'(valid_seen), 0);
    check_val("badlen_err_cnt", 32'(err_cnt - e0), 2);
    clear_mon();
    rx_byte(8'h55);
    rx_byte(8'h10);
    for (int i = 0; i < 16; i++) rx_byte(8'(i));
    rx_byte(8'h10);
    check_val("max_ok", 32'(frame_ok), 1);
    wait_idle(40);
    check_val("max_nbytes", 32'(q_data.size()), 16);
    if (q_data.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check_val($sformatf("max_b%0d", i), {23'd0, q_last[i], q_data[i]},
                  {23'd0, (i == 15), 8'(i)});
      end
    end

    // Timeout: fires exactly 64 cycles after the last byte
    e0 = err_cnt;
    rx_byte(8'h55);
    rx_byte(8'h04);
    rx_byte(8'hAA);
    idle(63);
    check_val("to_63_err", 32'(frame_err), 0);
    check_val("to_63_busy", 32'(busy), 1);
    idle(1);
    check_val("to_64_err", 32'(frame_err), 1);
    check_val("to_64_code", 32'(err_code), 3);
    check_val("to_64_busy", 32'(busy), 0);
    // A byte at cycle 63 keeps the frame alive (csum 04^AA^BB^CC^DD = 04)
    clear_mon();
    rx_byte(8'h55);
    rx_byte(8'h04);
    rx_byte(8'hAA);
    idle(62);
    rx_byte(8'hBB);
    check_val("to_edge_busy", 32'(busy), 1);
    idle(1);
    check_val("to_edge_noerr", 32'(frame_err), 0);
    rx_byte(8'hCC);
    rx_byte(8'hDD);
    rx_byte(8'h04);
    check_val("to_edge_ok", 32'(frame_ok), 1);
    wait_idle(20);
    check_val("to_err_cnt", 32'(err_cnt - e0), 1);
    check_val("to_edge_nbytes", 32'(q_data.size()), 4);

    // Backpressure with an overrun byte mid-drain (csum 03^11^22^33 = 03)
    clear_mon();
    e0 = err_cnt;
    out_ready = 1'b0;
    rx_byte(8'h55);
    rx_byte(8'h03);
    rx_byte(8'h11);
    rx_byte(8'h22);
    rx_byte(8'h33);
    rx_byte(8'h03);
    check_val("bp_ok", 32'(frame_ok), 1);
    check_val("bp_d0", 32'(out_data), 'h11);
    idle(1);
    check_val("bp_hold0", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
    out_ready = 1'b1;
    idle(1);
    check_val("bp_d1", 32'(out_data), 'h22);
    out_ready = 1'b0;
    rx_byte(8'h55);
    check_val("ovr_err", 32'(frame_err), 1);
    check_val("ovr_code", 32'(err_code), 0);
    check_val("bp_hold1", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
    out_ready = 1'b1;
    idle(1);
    check_val("bp_d2", {23'd0, out_last, out_data}, {23'd0, 1'b1, 8'h33});
    idle(1);
    check_val("bp_end_valid", 32'(out_valid), 0);
    check_val("bp_end_busy", 32'(busy), 0);
    check_val("bp_err_cnt", 32'(err_cnt - e0), 1);
    check_val("bp_nbytes", 32'(q_data.size()), 3);
    if (q_data.size() == 3) begin
      check_val("bp_order", {8'd0, q_data[0], q_data[1], q_data[2]}, 'h112233);
      check_val("bp_last", {29'd0, q_last[0], q_last[1], q_last[2]}, 'b001);
    end

    // Reset during PAYLOAD (err_code left at 01 beforehand)
    rx_byte(8'h55);
    rx_byte(8'h00);
    rx_byte(8'h55);
    rx_byte(8'h03);
    rx_byte(8'h01);
    check_val("rstp_pre_busy", 32'(busy), 1);
    #3 reset = 1'b1;
    #1;
    check_val("rstp_busy", 32'(busy), 0);
    check_val("rstp_code", 32'(err_code), 0);
    check_val("rstp_outs", {26'd0, out_valid, out_last, frame_ok, frame_err, 2'b00}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during DRAIN (csum 02^0A^0B = 03)
    out_ready = 1'b0;
    rx_byte(8'h55);
    rx_byte(8'h02);
    rx_byte(8'h0A);
    rx_byte(8'h0B);
    rx_byte(8'h03);
    check_val("rstd_pre_valid", 32'(out_valid), 1);
    #3 reset = 1'b1;
    #1;
    check_val("rstd_valid", 32'(out_valid), 0);
    check_val("rstd_data", 32'(out_data), 0);
    check_val("rstd_busy", 32'(busy), 0);
    check_val("rstd_ok", 32'(frame_ok), 0);
    @(negedge clk);
    reset = 1'b0;

    clear_mon();
    out_ready = 1'b1;
    rx_byte(8'h55);
    rx_byte(8'h01);
    rx_byte(8'h42);
    rx_byte(8'h43);
    check_val("post_rst_ok", 32'(frame_ok), 1);
    check_val("post_rst_data", {23'd0, out_last, out_data}, {23'd0, 1'b1, 8'h42});
    idle(3);
    check_val("post_rst_nbytes", 32'(q_data.size()), 1);
    check_val("post_rst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
